// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared types and constants for the PC unit.
// Build option: PCU_MISALIGN_CHECK_EN turns misaligned targets into a trap.
package pc_unit_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned PC_INC           = 4;

    // Issue/commit handshake phases of the single-outstanding core.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Where the next PC comes from after a commit.
    typedef enum logic [1:0] {
        SEQ   = 2'd0,
        REDIR = 2'd1,
        TRAP  = 2'd2,
        MRET  = 2'd3
    } pc_src_t;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux (trap > mret > redirect > seq)
// with word alignment of the selected target.
// Build option: PCU_MISALIGN_CHECK_EN reports a misaligned mepc/redirect target
// through fault and substitutes the (aligned) trap vector.
module pc_next_sel
    import pc_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
`ifdef PCU_MISALIGN_CHECK_EN
    output logic            fault,
`endif
    output logic [XLEN-1:0] next_pc
);

    pc_src_t         src;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] aligned_target;
    logic [XLEN-1:0] trap_base;

    // Pick the source by fixed priority among the commit qualifiers.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        src = SEQ;
        if (trap_valid) begin
            src = TRAP;
        end else if (mret_valid) begin
            src = MRET;
        end else if (redirect_valid) begin
            src = REDIR;
        end
    end

    // Route the chosen source to the raw target.
    always_comb begin
        raw_target = pc + XLEN'(PC_INC);
        case (src)
            TRAP:    raw_target = trap_vec;
            MRET:    raw_target = mepc;
            REDIR:   raw_target = redirect_target;
            default: raw_target = pc + XLEN'(PC_INC);
        endcase
    end

    assign aligned_target = {raw_target[XLEN-1:2], 2'b00};
    assign trap_base      = {trap_vec[XLEN-1:2], 2'b00};

`ifdef PCU_MISALIGN_CHECK_EN
    // A misaligned trap vector is just masked; only mepc/redirect can fault.
    always_comb begin
        fault   = ((src == MRET) || (src == REDIR)) && (raw_target[1:0] != 2'b00);
        next_pc = fault ? trap_base : aligned_target;
    end
`else
    // Without the check, low target bits are dropped silently.
    always_comb begin
        next_pc = aligned_target;
        if (src == TRAP) begin
            next_pc = trap_base;
        end
    end
`endif

endmodule

// File: rtl/pc_unit.sv
// pc_unit: owns the architectural PC, offers it to fetch with valid/ready,
// and advances it on commit. One instruction outstanding at a time.
// Build option: PCU_MISALIGN_CHECK_EN adds the misalign output pulse.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic            commit,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    input  logic            halt_req,
`ifdef PCU_MISALIGN_CHECK_EN
    output logic            misalign,
`endif
    output logic            halted,
    output logic [63:0]     instret
);

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] next_pc;
    logic            commit_take;
    logic            pc_load;
`ifdef PCU_MISALIGN_CHECK_EN
    logic            fault;
`endif

    pc_next_sel #(
        .XLEN            (XLEN)
    ) u_next_sel (
        .pc              (pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vec        (trap_vec),
        .mret_valid      (mret_valid),
        .mepc            (mepc),
`ifdef PCU_MISALIGN_CHECK_EN
        .fault           (fault),
`endif
        .next_pc         (next_pc)
    );

    // Commit only counts while an instruction is outstanding; elsewhere it is a protocol error.
    assign commit_take = (state == WAIT) && commit;
    assign pc_load     = commit_take && !halt_req;

    assign pc_valid = (state == ISSUE);
    assign halted   = (state == HALT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state <= ISSUE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: issue, wait for commit, or stop for good.
    always_comb begin
        state_next = state;
        case (state)
            ISSUE: if (pc_ready) state_next = WAIT;
            WAIT: begin
                if (commit) begin
                    state_next = halt_req ? HALT : ISSUE;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = ISSUE;
        endcase
    end

    // PC register: held while offered, reloaded only by a non-halting commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
            pc <= next_pc;
        end
    end

    // Retired-instruction counter; a halting instruction still retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= 64'd0;
        end else if (commit_take) begin
            instret <= instret + 64'd1;
        end
    end

`ifdef PCU_MISALIGN_CHECK_EN
    // One-cycle misalign pulse alongside the PC update that replaced the bad target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= pc_load && fault;
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit. Expected fetch PCs are
// queued when a commit is driven and popped when the unit offers the next PC.
`timescale 1ns/1ps
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        commit;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        mret_valid;
    logic [31:0] mepc;
    logic        halt_req;
    logic        halted;
    logic [63:0] instret;
`ifdef PCU_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [63:0] exp_instret;

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN            (32),
        .RESET_PC        (32'h8000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .pc_ready        (pc_ready),
        .commit          (commit),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vec        (trap_vec),
        .mret_valid      (mret_valid),
        .mepc            (mepc),
        .halt_req        (halt_req),
`ifdef PCU_MISALIGN_CHECK_EN
        .misalign        (misalign),
`endif
        .halted          (halted),
        .instret         (instret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference next-PC rule, written from the priority/alignment rules.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic trap,
                                               input logic [31:0] tvec, input logic mret,
                                               input logic [31:0] mepc_v, input logic redir,
                                               input logic [31:0] rtgt);
        logic [31:0] t;
        if (trap)       t = tvec;
        else if (mret)  t = mepc_v;
        else if (redir) t = rtgt;
        else            return cur + 32'd4;
`ifdef PCU_MISALIGN_CHECK_EN
        if (!trap && (t[1:0] != 2'b00)) return {tvec[31:2], 2'b00};
`endif
        return {t[31:2], 2'b00};
    endfunction

    task automatic clear_inputs();
        commit          = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        trap_valid      = 1'b0;
        trap_vec        = 32'd0;
        mret_valid      = 1'b0;
        mepc            = 32'd0;
        halt_req        = 1'b0;
    endtask

    // Wait (bounded) for an offered PC, compare it with the scoreboard, then accept it.
    task automatic accept(input string tag);
        int          waited;
        logic [31:0] exp;
        waited = 0;
        while (!pc_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!pc_valid) begin
            check({tag, " timeout"}, 64'(pc_valid), 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check({tag, " sb_empty"}, 64'(exp_q.size()), 64'd1);
            return;
        end
        exp = exp_q.pop_front();
        check({tag, " pc"}, 64'(pc), 64'(exp));
        pc_ready = 1'b1;
        @(negedge clk);
        pc_ready = 1'b0;
        check({tag, " to_wait"}, 64'(pc_valid), 64'd0);
    endtask

    // Drive one commit pulse with qualifiers and check its immediate effects.
    task automatic do_commit(input string tag, input logic halt, input logic trap,
                             input logic [31:0] tvec, input logic mret,
                             input logic [31:0] mepc_v, input logic redir,
                             input logic [31:0] rtgt);
        logic [31:0] cur;
        cur             = pc;
        halt_req        = halt;
        trap_valid      = trap;
        trap_vec        = tvec;
        mret_valid      = mret;
        mepc            = mepc_v;
        redirect_valid  = redir;
        redirect_target = rtgt;
        commit          = 1'b1;
        @(negedge clk);
        clear_inputs();
        exp_instret = exp_instret + 64'd1;
        check({tag, " instret"}, instret, exp_instret);
        if (halt) begin
            check({tag, " halted"}, 64'(halted), 64'd1);
            check({tag, " halt_valid"}, 64'(pc_valid), 64'd0);
            check({tag, " halt_pc"}, 64'(pc), 64'(cur));
        end else begin
            exp_q.push_back(model_next(cur, trap, tvec, mret, mepc_v, redir, rtgt));
            check({tag, " reissue"}, 64'(pc_valid), 64'd1);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        pc_ready = 1'b0;
        clear_inputs();
        exp_instret = 64'd0;
        repeat (2) @(negedge clk);
        check("rst pc", 64'(pc), 64'h8000_0000);
        check("rst pc_valid", 64'(pc_valid), 64'd1);
        check("rst halted", 64'(halted), 64'd0);
        check("rst instret", instret, 64'd0);
        rst = 1'b0;
        exp_q.push_back(32'h8000_0000);

        // Fetch stalls five cycles: offer must stay put.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall valid", 64'(pc_valid), 64'd1);
            check("stall pc", 64'(pc), 64'h8000_0000);
        end
        accept("issue0");
        do_commit("seq", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Commit while in ISSUE is ignored.
        commit          = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h1234_5678;
        @(negedge clk);
        clear_inputs();
        check("proto pc", 64'(pc), 64'h8000_0004);
        check("proto valid", 64'(pc_valid), 64'd1);
        check("proto instret", instret, exp_instret);

        accept("issue1");
        do_commit("trap_win", 1'b0, 1'b1, 32'h8000_0200, 1'b0, 32'd0, 1'b1, 32'h8000_0100);
        accept("issue2");
        do_commit("mret", 1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_0010, 1'b0, 32'd0);
        accept("issue3");
        do_commit("mret_vs_redir", 1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_0020, 1'b1, 32'h8000_0300);
        accept("issue4");
        do_commit("to_top", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        accept("issue5");
        do_commit("wrap", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        accept("issue6");

        // Misaligned redirect: trapped with the check, masked without it.
        do_commit("mis_redir", 1'b0, 1'b0, 32'h8000_0200, 1'b0, 32'd0, 1'b1, 32'h8000_0102);
`ifdef PCU_MISALIGN_CHECK_EN
        check("mis_pulse", 64'(misalign), 64'd1);
        check("mis_pc", 64'(pc), 64'h8000_0200);
`else
        check("mis_pc", 64'(pc), 64'h8000_0100);
`endif
        accept("issue7");
`ifdef PCU_MISALIGN_CHECK_EN
        check("mis_pulse_end", 64'(misalign), 64'd0);
`endif
        do_commit("mis_tvec", 1'b0, 1'b1, 32'h8000_0203, 1'b0, 32'd0, 1'b0, 32'd0);
`ifdef PCU_MISALIGN_CHECK_EN
        check("mis_tvec_quiet", 64'(misalign), 64'd0);
`endif
        accept("issue8");

        // Asynchronous reset while waiting for commit.
        #2 rst = 1'b1;
        commit = 1'b1;
        #1;
        check("arst pc", 64'(pc), 64'h8000_0000);
        check("arst instret", instret, 64'd0);
        check("arst valid", 64'(pc_valid), 64'd1);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h8000_0000);
        exp_instret = 64'd0;

        // Halt beats trap, retires, and is sticky.
        accept("issue9");
        do_commit("halt", 1'b1, 1'b1, 32'h8000_0200, 1'b0, 32'd0, 1'b0, 32'd0);
        pc_ready       = 1'b1;
        commit         = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h8000_0400;
        repeat (3) @(negedge clk);
        clear_inputs();
        pc_ready = 1'b0;
        @(negedge clk);
        check("halt sticky", 64'(halted), 64'd1);
        check("halt no_valid", 64'(pc_valid), 64'd0);
        check("halt instret", instret, exp_instret);
        check("halt pc", 64'(pc), 64'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
